// File: rtl/pcie_cpld_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcie_cpld_tx_pkg
// Description : CplD header constants, request record and FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pcie_cpld_tx_pkg;

  localparam logic [7:0]  FMT_TYPE_CPLD  = 8'h4A;
  localparam logic [2:0]  CPL_SC         = 3'b000;
  localparam logic [11:0] BYTE_COUNT_1DW = 12'h004;
  localparam logic [9:0]  LENGTH_1DW     = 10'd1;
  localparam logic [2:0]  LAST_WORD      = 3'd7;
  localparam int          REQ_W          = 63;

  typedef struct packed {
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [6:0]  laddr;
    logic [31:0] data;
  } cpl_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2
  } cpl_state_t;

  // Word idx of the 3-DW CplD header plus its single data DW, big-endian.
  function automatic logic [15:0] cpld_word(input logic [2:0] idx,
                                            input cpl_req_t  req,
                                            input logic [15:0] cid);
    logic [15:0] w;
    w = 16'h0000;
    case (idx)
      3'd0:    w = {FMT_TYPE_CPLD, 8'h00};
      3'd1:    w = {6'b000000, LENGTH_1DW};
      3'd2:    w = cid;
      3'd3:    w = {CPL_SC, 1'b0, BYTE_COUNT_1DW};
      3'd4:    w = req.rid;
      3'd5:    w = {req.tag, 1'b0, req.laddr};
      3'd6:    w = req.data[31:16];
      default: w = req.data[15:0];
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_cpld_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : pcie_cpld_tx_if
// Description : Request-in and core-transmit handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface pcie_cpld_tx_if;

  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_rid;
  logic [7:0]  req_tag;
  logic [6:0]  req_laddr;
  logic [31:0] req_data;

  logic        tx_req;
  logic        tx_rdy;
  logic        tx_st;
  logic        tx_end;
  logic [15:0] tx_data;

  // master: the completion transmitter; slave: request source plus PCIe core
  modport master (
    input  req_valid, req_rid, req_tag, req_laddr, req_data, tx_rdy,
    output req_ready, tx_req, tx_st, tx_end, tx_data
  );

  modport slave (
    output req_valid, req_rid, req_tag, req_laddr, req_data, tx_rdy,
    input  req_ready, tx_req, tx_st, tx_end, tx_data
  );

endinterface
`default_nettype wire

// File: rtl/pcie_cpld_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pcie_cpld_req_fifo
// Description : Single-clock request FIFO with registered full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_cpld_req_fifo #(
  parameter int WIDTH   = 63,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   wr_data_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   rd_data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [FIFO_AW:0]   count_o
);

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam int               CNT_W     = FIFO_AW + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, empty_q;
  logic               do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i  & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)
      count_d = count_q + CNT_ONE;
    else if (!do_push && do_pop)
      count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_CNT);
      empty_q <= (count_d == '0);
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign count_o   = count_q;

endmodule
`default_nettype wire

// File: rtl/pcie_cpld_tx.sv
`default_nettype none
// ============================================================================
// Module      : pcie_cpld_tx
// Description : Queues 1-DW read requests and serialises one CplD per request.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_cpld_tx
  import pcie_cpld_tx_pkg::*;
#(
  parameter int FIFO_AW = 2
) (
  input  logic                  pcie_clk,
  input  logic                  sys_rst,
  input  logic [7:0]            bus_num,
  input  logic [4:0]            dev_num,
  input  logic [2:0]            func_num,
  pcie_cpld_tx_if.master        bif,
  output logic [15:0]           cpl_sent
);

  localparam logic [FIFO_AW:0] CNT_ONE = (FIFO_AW + 1)'(1);

  cpl_req_t           in_req;
  cpl_req_t           head_req;
  logic               push, pop;
  logic               fifo_full, fifo_empty;
  logic [FIFO_AW:0]   fifo_count;
  logic               more_after_pop;
  logic [15:0]        cid;
  logic [2:0]         next_idx;

  cpl_state_t         state_q;
  logic [2:0]         idx_q;
  logic               busy_q;
  logic               tx_req_q, tx_st_q, tx_end_q;
  logic [15:0]        tx_data_q;
  logic [15:0]        cpl_sent_q;

  assign in_req = {bif.req_rid, bif.req_tag, bif.req_laddr, bif.req_data};
  assign push   = bif.req_valid & ~fifo_full;
  assign pop    = (state_q == ST_SEND) & busy_q & bif.tx_rdy & (idx_q == LAST_WORD);

  pcie_cpld_req_fifo #(
    .WIDTH   (REQ_W),
    .FIFO_AW (FIFO_AW)
  ) u_req_fifo (
    .clk       (pcie_clk),
    .rst       (sys_rst),
    .push_i    (push),
    .wr_data_i (in_req),
    .pop_i     (pop),
    .rd_data_o (head_req),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign cid            = {bus_num, dev_num, func_num};
  assign next_idx       = idx_q + 3'd1;
  // A push landing on the pop cycle also counts as a remaining entry.
  assign more_after_pop = (fifo_count > CNT_ONE) | push;

  // busy_q marks that a word is on tx_data; the SEND cycle before it loads w0.
  always_ff @(posedge pcie_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      busy_q     <= 1'b0;
      tx_req_q   <= 1'b0;
      tx_st_q    <= 1'b0;
      tx_end_q   <= 1'b0;
      tx_data_q  <= 16'h0000;
      cpl_sent_q <= 16'h0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q  <= ST_REQ;
            tx_req_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bif.tx_rdy) begin
            state_q  <= ST_SEND;
            tx_req_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        ST_SEND: begin
          if (!busy_q) begin
            busy_q    <= 1'b1;
            idx_q     <= 3'd0;
            tx_data_q <= cpld_word(3'd0, head_req, cid);
            tx_st_q   <= 1'b1;
            tx_end_q  <= 1'b0;
          end else if (bif.tx_rdy) begin
            if (idx_q == LAST_WORD) begin
              busy_q     <= 1'b0;
              tx_data_q  <= 16'h0000;
              tx_st_q    <= 1'b0;
              tx_end_q   <= 1'b0;
              cpl_sent_q <= cpl_sent_q + 16'd1;
              if (more_after_pop) begin
                state_q  <= ST_REQ;
                tx_req_q <= 1'b1;
              end else begin
                state_q  <= ST_IDLE;
              end
            end else begin
              idx_q     <= next_idx;
              tx_data_q <= cpld_word(next_idx, head_req, cid);
              tx_st_q   <= 1'b0;
              tx_end_q  <= (next_idx == LAST_WORD);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bif.req_ready = ~fifo_full;
  assign bif.tx_req    = tx_req_q;
  assign bif.tx_st     = tx_st_q;
  assign bif.tx_end    = tx_end_q;
  assign bif.tx_data   = tx_data_q;
  assign cpl_sent      = cpl_sent_q;

endmodule
`default_nettype wire
